// File: rtl/rab_pkg.sv
// rab_pkg: shared widths, requester IDs and field positions for the RAB translation path
package rab_pkg;
    localparam int RAB_REQ_W     = 43;
    localparam int RAB_RESP_W    = 33;
    localparam int RESP_DONE_BIT = 32;
    localparam int VADDR_MSB     = 31;
    typedef enum logic {REQ_ID_RD = 1'b0, REQ_ID_WR = 1'b1} req_id_e;
endpackage

// File: rtl/rab_tag_fifo.sv
// rab_tag_fifo: 1-bit requester-ID FIFO recording the issue order of translations
module rab_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_,
    input  logic                         push_i,
    input  logic                         data_i,
    input  logic                         pop_i,
    output logic                         data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;
    assign empty_o = count_q == '0;
    assign full_o  = count_q == CW'(DEPTH);
    assign do_pop  = pop_i & !empty_o;
    // a full FIFO still accepts a push when the same cycle pops
    assign do_push = push_i & (!full_o | do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/rab_xlat_arbiter.sv
// rab_xlat_arbiter: round-robin sharing of one translator between the AR and AW request streams,
// with in-order response routing back to the issuing side and per-direction fault counting
module rab_xlat_arbiter
    import rab_pkg::*;
#(
    parameter int REQ_W     = RAB_REQ_W,
    parameter int RESP_W    = RAB_RESP_W,
    parameter int MAX_OUTST = 4,
    parameter int CNT_W     = 16
) (
    input  logic                             clk,
    input  logic                             reset_,
    input  logic [REQ_W-1:0]                 s_rd_tdata,
    input  logic                             s_rd_tvalid,
    output logic                             s_rd_tready,
    input  logic [REQ_W-1:0]                 s_wr_tdata,
    input  logic                             s_wr_tvalid,
    output logic                             s_wr_tready,
    output logic [REQ_W-1:0]                 m_xl_tdata,
    output logic                             m_xl_tvalid,
    input  logic                             m_xl_tready,
    input  logic [RESP_W-1:0]                s_xl_tdata,
    input  logic                             s_xl_tvalid,
    output logic                             s_xl_tready,
    output logic [RESP_W-1:0]                m_rd_tdata,
    output logic                             m_rd_tvalid,
    input  logic                             m_rd_tready,
    output logic [RESP_W-1:0]                m_wr_tdata,
    output logic                             m_wr_tvalid,
    input  logic                             m_wr_tready,
    output logic [CNT_W-1:0]                 rd_fault_cnt,
    output logic [CNT_W-1:0]                 wr_fault_cnt,
    output logic [$clog2(MAX_OUTST+1)-1:0]   outstanding,
    output logic                             err_orphan
);
    logic              can_issue, sel_wr, grant, fifo_full, fifo_empty, head_id, head_free, pop, fault;
    req_id_e           last_q;
    logic [REQ_W-1:0]  xl_data_q;
    logic              xl_valid_q, rd_valid_q, wr_valid_q, orphan_q;
    logic [RESP_W-1:0] rd_data_q, wr_data_q;
    logic [CNT_W-1:0]  rd_cnt_q, wr_cnt_q;

    // fifo full is exactly the outstanding == MAX_OUTST stall condition
    assign can_issue   = (!xl_valid_q | m_xl_tready) & !fifo_full;
    assign sel_wr      = s_wr_tvalid & (!s_rd_tvalid | last_q == REQ_ID_RD);
    assign grant       = can_issue & (s_rd_tvalid | s_wr_tvalid);
    assign s_rd_tready = grant & !sel_wr;
    assign s_wr_tready = grant & sel_wr;
    assign head_free   = (head_id == REQ_ID_WR) ? (!wr_valid_q | m_wr_tready) : (!rd_valid_q | m_rd_tready);
    assign s_xl_tready = fifo_empty | head_free;
    assign pop         = s_xl_tvalid & !fifo_empty & head_free;
    assign fault       = !s_xl_tdata[RESP_DONE_BIT];

    rab_tag_fifo #(.DEPTH(MAX_OUTST)) u_tag_fifo (
        .clk     (clk),
        .reset_  (reset_),
        .push_i  (grant),
        .data_i  (sel_wr),
        .pop_i   (pop),
        .data_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (outstanding)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            last_q     <= REQ_ID_WR;
            xl_data_q  <= '0;
            xl_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            wr_data_q  <= '0;
            wr_valid_q <= 1'b0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            orphan_q   <= 1'b0;
        end else begin
            if (grant) begin
                xl_data_q  <= sel_wr ? s_wr_tdata : s_rd_tdata;
                xl_valid_q <= 1'b1;
                last_q     <= req_id_e'(sel_wr);
            end else if (m_xl_tready) begin
                xl_valid_q <= 1'b0;
            end
            if (pop && head_id == REQ_ID_RD) begin
                rd_data_q  <= s_xl_tdata;
                rd_valid_q <= 1'b1;
                if (fault && !(&rd_cnt_q)) rd_cnt_q <= rd_cnt_q + 1'b1;
            end else if (m_rd_tready) begin
                rd_valid_q <= 1'b0;
            end
            if (pop && head_id == REQ_ID_WR) begin
                wr_data_q  <= s_xl_tdata;
                wr_valid_q <= 1'b1;
                if (fault && !(&wr_cnt_q)) wr_cnt_q <= wr_cnt_q + 1'b1;
            end else if (m_wr_tready) begin
                wr_valid_q <= 1'b0;
            end
            if (s_xl_tvalid && fifo_empty) orphan_q <= 1'b1;
        end
    end

    assign m_xl_tdata   = xl_data_q;
    assign m_xl_tvalid  = xl_valid_q;
    assign m_rd_tdata   = rd_data_q;
    assign m_rd_tvalid  = rd_valid_q;
    assign m_wr_tdata   = wr_data_q;
    assign m_wr_tvalid  = wr_valid_q;
    assign rd_fault_cnt = rd_cnt_q;
    assign wr_fault_cnt = wr_cnt_q;
    assign err_orphan   = orphan_q;
endmodule

// File: tb/tb_rab_xlat_arbiter.sv
// tb_rab_xlat_arbiter: directed scenarios plus random traffic, checked every cycle against a
// transaction-level queue model of arbitration, in-order routing and fault counting
module tb_rab_xlat_arbiter;
    localparam int CNT_W = 4;
    localparam int MAXO  = 4;

    logic clk = 1'b0;
    logic reset_ = 1'b1;
    logic [42:0] s_rd_tdata, s_wr_tdata, m_xl_tdata;
    logic s_rd_tvalid, s_rd_tready, s_wr_tvalid, s_wr_tready, m_xl_tvalid, m_xl_tready;
    logic [32:0] s_xl_tdata, m_rd_tdata, m_wr_tdata;
    logic s_xl_tvalid, s_xl_tready, m_rd_tvalid, m_rd_tready, m_wr_tvalid, m_wr_tready;
    logic [CNT_W-1:0] rd_fault_cnt, wr_fault_cnt;
    logic [2:0] outstanding;
    logic err_orphan;

    always #5 clk = ~clk;

    rab_xlat_arbiter #(.REQ_W(43), .RESP_W(33), .MAX_OUTST(MAXO), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_(reset_),
        .s_rd_tdata(s_rd_tdata), .s_rd_tvalid(s_rd_tvalid), .s_rd_tready(s_rd_tready),
        .s_wr_tdata(s_wr_tdata), .s_wr_tvalid(s_wr_tvalid), .s_wr_tready(s_wr_tready),
        .m_xl_tdata(m_xl_tdata), .m_xl_tvalid(m_xl_tvalid), .m_xl_tready(m_xl_tready),
        .s_xl_tdata(s_xl_tdata), .s_xl_tvalid(s_xl_tvalid), .s_xl_tready(s_xl_tready),
        .m_rd_tdata(m_rd_tdata), .m_rd_tvalid(m_rd_tvalid), .m_rd_tready(m_rd_tready),
        .m_wr_tdata(m_wr_tdata), .m_wr_tvalid(m_wr_tvalid), .m_wr_tready(m_wr_tready),
        .rd_fault_cnt(rd_fault_cnt), .wr_fault_cnt(wr_fault_cnt),
        .outstanding(outstanding), .err_orphan(err_orphan)
    );

    // reference model: requests waiting at the translator port, issue-order tags, routed responses
    logic [42:0] xl_q[$];
    bit          tags[$];
    logic [32:0] rd_q[$], wr_q[$];
    int  rd_f, wr_f, tr_pend;
    bit  orph, last_wr;
    int  n_tests = 0, n_fail = 0;
    int  n_drd, n_dwr, n_dxl, n_drdo;
    bit  dut_rd_hs, dut_wr_hs, dut_xs_hs;
    bit  auto_src, auto_tr, auto_rdy;
    int  rd_pct, wr_pct, tr_pct, rdy_pct, resp_mode;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic mreset();
        xl_q.delete(); tags.delete(); rd_q.delete(); wr_q.delete();
        rd_f = 0; wr_f = 0; tr_pend = 0; orph = 0; last_wr = 1;
        dut_rd_hs = 0; dut_wr_hs = 0; dut_xs_hs = 0;
    endtask

    task automatic tick();
        bit can, g_rd, g_wr, x_rdy, sd;
        @(negedge clk);
        can   = (xl_q.size() == 0 || m_xl_tready) && tags.size() < MAXO;
        g_rd  = can && s_rd_tvalid && (!s_wr_tvalid || last_wr);
        g_wr  = can && s_wr_tvalid && (!s_rd_tvalid || !last_wr);
        x_rdy = tags.size() == 0 ? 1'b1 : tags[0] ? (wr_q.size() == 0 || m_wr_tready) : (rd_q.size() == 0 || m_rd_tready);
        chk("rd_ready", s_rd_tready, g_rd);
        chk("wr_ready", s_wr_tready, g_wr);
        chk("xl_valid", m_xl_tvalid, xl_q.size() != 0);
        if (xl_q.size() != 0) chk("xl_data", m_xl_tdata, xl_q[0]);
        chk("rd_valid", m_rd_tvalid, rd_q.size() != 0);
        if (rd_q.size() != 0) chk("rd_data", m_rd_tdata, rd_q[0]);
        chk("wr_valid", m_wr_tvalid, wr_q.size() != 0);
        if (wr_q.size() != 0) chk("wr_data", m_wr_tdata, wr_q[0]);
        chk("xl_resp_ready", s_xl_tready, x_rdy);
        chk("outstanding", outstanding, tags.size());
        chk("rd_fault_cnt", rd_fault_cnt, rd_f);
        chk("wr_fault_cnt", wr_fault_cnt, wr_f);
        chk("err_orphan", err_orphan, orph);
        dut_rd_hs = s_rd_tvalid && s_rd_tready;
        dut_wr_hs = s_wr_tvalid && s_wr_tready;
        dut_xs_hs = s_xl_tvalid && s_xl_tready;
        n_drd += int'(dut_rd_hs);
        n_dwr += int'(dut_wr_hs);
        if (m_xl_tvalid && m_xl_tready) begin tr_pend++; n_dxl++; end
        if (m_rd_tvalid && m_rd_tready) n_drdo++;
        if (rd_q.size() != 0 && m_rd_tready) void'(rd_q.pop_front());
        if (wr_q.size() != 0 && m_wr_tready) void'(wr_q.pop_front());
        if (xl_q.size() != 0 && m_xl_tready) void'(xl_q.pop_front());
        if (s_xl_tvalid && x_rdy) begin
            if (tags.size() == 0) orph = 1;
            else begin
                sd = tags.pop_front();
                if (sd) begin wr_q.push_back(s_xl_tdata); if (!s_xl_tdata[32] && wr_f < 15) wr_f++; end
                else begin rd_q.push_back(s_xl_tdata); if (!s_xl_tdata[32] && rd_f < 15) rd_f++; end
            end
        end
        if (g_rd) begin xl_q.push_back(s_rd_tdata); tags.push_back(1'b0); last_wr = 0; end
        if (g_wr) begin xl_q.push_back(s_wr_tdata); tags.push_back(1'b1); last_wr = 1; end
        @(posedge clk);
        #1;
    endtask

    task automatic drive();
        if (auto_src) begin
            if (!s_rd_tvalid || dut_rd_hs) begin
                s_rd_tvalid = $urandom_range(1, 100) <= rd_pct;
                s_rd_tdata  = {11'($urandom), 32'($urandom)};
            end
            if (!s_wr_tvalid || dut_wr_hs) begin
                s_wr_tvalid = $urandom_range(1, 100) <= wr_pct;
                s_wr_tdata  = {11'($urandom), 32'($urandom)};
            end
        end
        if (auto_tr && (!s_xl_tvalid || dut_xs_hs)) begin
            s_xl_tvalid = 0;
            if (tr_pend > 0 && $urandom_range(1, 100) <= tr_pct) begin
                s_xl_tvalid = 1;
                s_xl_tdata  = {(resp_mode == 0) ? 1'($urandom) : 1'(resp_mode == 1), 32'($urandom)};
                tr_pend--;
            end
        end
        if (auto_rdy) begin
            m_xl_tready = $urandom_range(1, 100) <= rdy_pct;
            m_rd_tready = $urandom_range(1, 100) <= rdy_pct;
            m_wr_tready = $urandom_range(1, 100) <= rdy_pct;
        end
    endtask

    task automatic drain();
        int k = 0;
        auto_src = 1; rd_pct = 0; wr_pct = 0; auto_tr = 1; tr_pct = 100; auto_rdy = 0;
        m_xl_tready = 1; m_rd_tready = 1; m_wr_tready = 1;
        s_rd_tvalid = 0; s_wr_tvalid = 0;
        while ((tags.size() != 0 || xl_q.size() != 0 || rd_q.size() != 0 || wr_q.size() != 0 || s_xl_tvalid) && k < 200) begin
            drive();
            tick();
            k++;
        end
        chk("drain_timeout", k >= 200, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        s_rd_tvalid = 0; s_wr_tvalid = 0; s_xl_tvalid = 0;
        s_rd_tdata = '0; s_wr_tdata = '0; s_xl_tdata = '0;
        m_xl_tready = 1; m_rd_tready = 1; m_wr_tready = 1;
        auto_src = 0; auto_tr = 0; auto_rdy = 0;
        rd_pct = 0; wr_pct = 0; tr_pct = 100; rdy_pct = 100; resp_mode = 1;
        n_drd = 0; n_dwr = 0; n_dxl = 0; n_drdo = 0;
        mreset();
        #2 reset_ = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_xl_valid", m_xl_tvalid, 0);
        chk("rst_rd_valid", m_rd_tvalid, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_orphan", err_orphan, 0);
        reset_ = 1;

        // single read translation routed to the read side only
        s_rd_tvalid = 1; s_rd_tdata = 43'h1234;
        tick();
        s_rd_tvalid = 0;
        repeat (3) tick();
        s_xl_tvalid = 1; s_xl_tdata = 33'h1_0000_2234; tr_pend--;
        tick();
        s_xl_tvalid = 0;
        chk("t1_rd_valid", m_rd_tvalid, 1);
        chk("t1_rd_data", m_rd_tdata, 33'h1_0000_2234);
        chk("t1_wr_valid", m_wr_tvalid, 0);
        chk("t1_outstanding", outstanding, 0);
        tick();

        // both sides always requesting: grants must alternate
        n_drd = 0; n_dwr = 0;
        auto_src = 1; rd_pct = 100; wr_pct = 100; auto_tr = 1; tr_pct = 100;
        repeat (20) begin drive(); tick(); end
        chk("t2_rd_grants", n_drd >= 8, 1);
        chk("t2_wr_grants", n_dwr >= 8, 1);
        chk("t2_balance", n_drd - n_dwr <= 1 && n_dwr - n_drd <= 1, 1);
        drain();

        // silent translator: issue stops at the outstanding limit
        auto_src = 1; rd_pct = 100; wr_pct = 100; auto_tr = 0; n_dxl = 0;
        repeat (10) begin drive(); tick(); end
        chk("t3_issued", n_dxl, 4);
        chk("t3_rd_ready", s_rd_tready, 0);
        chk("t3_wr_ready", s_wr_tready, 0);
        s_xl_tvalid = 1; s_xl_tdata = {1'b1, 32'($urandom)}; tr_pend--;
        drive(); tick();
        s_xl_tvalid = 0;
        repeat (10) begin drive(); tick(); end
        chk("t3_issued_after_resp", n_dxl, 5);
        drain();

        // stalled read output blocks a later write response
        auto_src = 0; auto_tr = 1; tr_pct = 100; m_rd_tready = 0;
        s_rd_tvalid = 1; s_rd_tdata = {11'($urandom), 32'($urandom)};
        drive(); tick();
        s_rd_tdata = {11'($urandom), 32'($urandom)};
        drive(); tick();
        s_rd_tvalid = 0; s_wr_tvalid = 1; s_wr_tdata = {11'($urandom), 32'($urandom)};
        drive(); tick();
        s_wr_tvalid = 0;
        repeat (10) begin drive(); tick(); end
        chk("t4_wr_blocked", m_wr_tvalid, 0);
        chk("t4_rd_held", m_rd_tvalid, 1);
        chk("t4_xl_ready", s_xl_tready, 0);
        drain();

        // read faults saturate the 4-bit counter
        n_drdo = 0; resp_mode = 2;
        auto_src = 1; rd_pct = 100; wr_pct = 0; auto_tr = 1; tr_pct = 100;
        for (int k = 0; k < 300 && n_drdo < 17; k++) begin drive(); tick(); end
        chk("t5_rd_responses", n_drdo >= 17, 1);
        drain();
        chk("t5_rd_fault_sat", rd_fault_cnt, 4'hF);
        chk("t5_wr_fault", wr_fault_cnt, 0);
        resp_mode = 1;

        // orphan response with nothing in flight
        auto_src = 0; auto_tr = 0;
        s_xl_tvalid = 1; s_xl_tdata = {1'b1, 32'($urandom)};
        tick();
        s_xl_tvalid = 0;
        tick();
        chk("t6_orphan", err_orphan, 1);

        // async reset with two in flight
        s_rd_tvalid = 1; s_wr_tvalid = 1;
        for (int k = 0; k < 20 && tags.size() < 2; k++) tick();
        s_rd_tvalid = 0; s_wr_tvalid = 0;
        reset_ = 0;
        #1;
        chk("t6_rst_xl_valid", m_xl_tvalid, 0);
        chk("t6_rst_outstanding", outstanding, 0);
        chk("t6_rst_orphan", err_orphan, 0);
        chk("t6_rst_rd_fault", rd_fault_cnt, 0);
        mreset();
        repeat (2) @(posedge clk);
        #1 reset_ = 1;
        s_xl_tvalid = 1; s_xl_tdata = {1'b1, 32'($urandom)};
        tick();
        s_xl_tvalid = 0;
        tick();
        chk("t6_late_orphan", err_orphan, 1);
        s_rd_tvalid = 1; s_wr_tvalid = 1;
        tick();
        chk("t6_first_rd", dut_rd_hs, 1);
        chk("t6_first_not_wr", dut_wr_hs, 0);
        drain();

        // random traffic with random backpressure everywhere
        resp_mode = 0; auto_src = 1; rd_pct = 50; wr_pct = 50;
        auto_tr = 1; tr_pct = 50; auto_rdy = 1; rdy_pct = 70;
        repeat (3000) begin drive(); tick(); end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
